rf_dac_stream_src: RTL and testbench
====================================

Name: rf_dac_stream_src

Overview:
- Waveform playback transmitter that drives the RF DAC stream input: 256-bit words, 16 samples x 16-bit, on the DAC user clock.
- Words are held in an internal waveform RAM that control logic loads through a simple write port.
- Plays one pass or loops continuously, with full AXI-Stream tvalid/tready compliance.
- Sits between the DAC-side control/register logic and the RF data converter's s00 stream port.

Parameters:
- DATA_W, 256, stream word width in bits (16 samples x 16-bit).
- ADDR_W, 8, waveform RAM address width; depth = 2^ADDR_W words.
- CNT_W, 16, width of the completed-pass counter.

Ports:
- dac_usr_clk  in  1  sole clock (DAC user clock).
- dac_usr_rstb  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- wr_en  in  1  waveform RAM write strobe.
- wr_addr  in  ADDR_W  waveform RAM write address.
- wr_data  in  DATA_W  waveform RAM write data.
- cfg_len  in  ADDR_W+1  words per pass; valid range 1..2^ADDR_W.
- cfg_loop  in  1  1 = loop continuously, 0 = single pass.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle graceful-stop pulse.
- m_axis_tdata  out  DATA_W  stream data to the DAC.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready from the DAC.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when playback ends.
- pass_cnt  out  CNT_W  completed passes since the last start; saturates.
- err_len  out  1  one-cycle pulse when start is rejected because cfg_len == 0 or cfg_len > 2^ADDR_W.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, busy=0, done=0, pass_cnt=0, err_len=0, state=IDLE. RAM contents are not reset.
- Reset asserted mid-playback aborts immediately. tvalid drops asynchronously and no done pulse is generated.
- RAM: one write port, one read port, read latency 1.
  - Writes are accepted in any state.
  - Same-address write and read in one cycle returns the old data.
- States: IDLE, RUN, LAST.
- IDLE:
  - start with a valid cfg_len: latch len and loop, clear pass_cnt, set busy, go to RUN.
  - start with an invalid cfg_len: pulse err_len, stay in IDLE.
  - stop is ignored.
- Start latency: start at cycle N gives m_axis_tvalid=1 with word 0 at cycle N+2.
- RUN:
  - Read address walks 0..len-1.
  - Internal 2-entry prefetch buffer; reads issue only while outstanding plus stored entries < 2.
  - Throughput is 1 word/cycle while tready stays high.
  - Wrap from len-1 back to 0 occurs only when the loop latch = 1; otherwise the read side stops after len-1.
- Handshake rules:
  - While tvalid=1 and tready=0, tdata and tvalid hold stable.
  - tvalid never depends combinationally on tready.
- pass_cnt increments on the handshake of word len-1 and saturates at all-ones.
- len=1 with loop: word 0 repeats every cycle.
- stop in RUN clears the loop latch and moves to LAST. The current pass completes and no word past len-1 is issued.
  - If stop arrives in the same cycle as the handshake of word len-1, that handshake ends playback.
- start while busy is ignored. stop together with start in IDLE: start wins, stop is ignored.
- LAST: after the handshake of word len-1, tvalid=0 next cycle, done pulses for one cycle, busy=0, return to IDLE.
- Non-loop pass: identical end sequence to LAST.
- cfg_len and cfg_loop changes while busy have no effect until the next start.

Optional Feature:
- Macro RF_DAC_SRC_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Counts cycles with tvalid=1 and tready=0 while busy; saturates at 0xFFFFFFFF.
  - Cleared on accepted start and on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load words 0..3 with 0x..01..0x..04, len=4, loop=0, tready=1, pulse start -> tvalid at start+2; words 1,2,3,4 on 4 consecutive cycles; done 1 cycle after last; pass_cnt=1; busy=0.
- Same setup, loop=1, run 10 cycles, then pulse stop mid-pass -> sequence 1,2,3,4,1,2,... continues to the end of the current pass; done 1 cycle after word 4 handshake; pass_cnt=number of completed passes (e.g. 3).
- Loop=1, random tready at 50% -> no word dropped or duplicated; tdata stable during every stall; output equals the RAM pattern in order; with RF_DAC_SRC_STALL_CNT_EN, stall_cnt equals the counted stall cycles.
- cfg_len=0 start -> err_len pulse, busy stays 0, tvalid 0. cfg_len=256 with ADDR_W=8 -> accepted, plays all 256 words.
- Assert dac_usr_rstb=0 mid-pass with tvalid=1 -> tvalid=0 immediately, no done pulse; after release, start replays from word 0.
- len=1, loop=1, tready=1 -> word 0 presented every cycle; pass_cnt increments each cycle. Write wr_addr=0 during playback -> new value appears within 3 cycles.

Source files
------------

// File: rtl/rf_dac_stream_src.sv
// rf_dac_stream_src: waveform RAM playback source for the RF DAC s00 stream.
// Words are preloaded through a write port and streamed as an AXI-Stream
// master, either as one pass or looping, with a graceful stop that finishes
// the current pass.
// Optional build macro: RF_DAC_SRC_STALL_CNT_EN adds a 32-bit stall counter
// output (stall_cnt).
//
// state | meaning
// IDLE  | waiting for start; output empty
// RUN   | streaming; wraps to word 0 when the loop latch is set
// LAST  | stop seen; finishing the current pass, then done
module rf_dac_stream_src #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              dac_usr_clk,
  input  logic              dac_usr_rstb,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
`ifdef RF_DAC_SRC_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              err_len
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LAST} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_pend, r_rd_last, r_rd_active, r_loop;
  logic [ADDR_W-1:0] r_rd_addr, r_len_m1;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic              r_out_vld, r_out_last, r_skid_vld, r_skid_last;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic              r_done, r_err;

  logic              w_len_ok, w_start_ok, w_start_bad, w_stop_run, w_end;
  logic              w_pop, w_issue, w_rd_last, w_loop_eff;
  logic [1:0]        w_occ;
  logic [ADDR_W-1:0] w_rd_addr, w_len_m1;

  // len is valid for 1..2^ADDR_W; the MSB set is only legal for exactly 2^ADDR_W
  assign w_len_ok = cfg_len[ADDR_W] ? (cfg_len[ADDR_W-1:0] == '0) : (cfg_len != '0);
  assign w_pop    = r_out_vld & m_axis_tready;

  // Occupancy after this cycle's pop: in-flight read plus both buffer slots.
  // Counting the pop lets a read issue every cycle while tready stays high.
  assign w_occ      = {1'b0, r_rd_pend} + {1'b0, r_out_vld} + {1'b0, r_skid_vld} - {1'b0, w_pop};
  assign w_issue    = w_start_ok | (r_rd_active & ~w_end & (w_occ < 2'd2));
  assign w_rd_addr  = w_start_ok ? '0 : r_rd_addr;
  assign w_len_m1   = w_start_ok ? ADDR_W'(cfg_len - 1'b1) : r_len_m1;
  assign w_loop_eff = w_start_ok ? cfg_loop : (r_loop & ~w_stop_run);
  assign w_rd_last  = (w_rd_addr == w_len_m1);

  // State register
  always_ff @(posedge dac_usr_clk or negedge dac_usr_rstb) begin
    if (!dac_usr_rstb) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next state; playback ends on the handshake of a last-of-pass word once
  // looping is off (a stop in the same cycle counts as looping off)
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_stop_run  = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_stop_run = stop;
        w_end      = w_pop & r_out_last & (~r_loop | stop);
        if (w_end)     w_state_nxt = ST_IDLE;
        else if (stop) w_state_nxt = ST_LAST;
      end
      ST_LAST: begin
        w_end = w_pop & r_out_last;
        if (w_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Waveform RAM: registered read, so a same-address write returns old data
  always_ff @(posedge dac_usr_clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Config latches and read-address sequencer
  always_ff @(posedge dac_usr_clk or negedge dac_usr_rstb) begin
    if (!dac_usr_rstb) begin
      r_len_m1    <= '0;
      r_loop      <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_active <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_len_m1 <= w_len_m1;
        r_loop   <= cfg_loop;
      end else if (w_stop_run) begin
        r_loop <= 1'b0;
      end
      r_rd_pend <= w_issue;
      r_rd_last <= w_rd_last;
      if (w_end) begin
        r_rd_active <= 1'b0;
      end else if (w_issue) begin
        if (w_rd_last) begin
          r_rd_addr   <= '0;
          r_rd_active <= w_loop_eff;
        end else begin
          r_rd_addr   <= w_rd_addr + 1'b1;
          r_rd_active <= 1'b1;
        end
      end
    end
  end

  // Two-entry output buffer (output register + skid); words read past the
  // final pass are flushed when playback ends
  always_ff @(posedge dac_usr_clk or negedge dac_usr_rstb) begin
    if (!dac_usr_rstb) begin
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_skid_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
    end else if (w_end) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || w_pop) begin
      if (r_skid_vld) begin
        r_out_data  <= r_skid_data;
        r_out_last  <= r_skid_last;
        r_skid_vld  <= r_rd_pend;
        r_skid_data <= r_rd_data;
        r_skid_last <= r_rd_last;
      end else begin
        r_out_vld <= r_rd_pend;
        if (r_rd_pend) begin
          r_out_data <= r_rd_data;
          r_out_last <= r_rd_last;
        end
      end
    end else if (r_rd_pend) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= r_rd_data;
      r_skid_last <= r_rd_last;
    end
  end

  // Status: done/err pulses and saturating pass counter
  always_ff @(posedge dac_usr_clk or negedge dac_usr_rstb) begin
    if (!dac_usr_rstb) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pass_cnt <= '0;
    end else begin
      r_done <= w_end;
      r_err  <= w_start_bad;
      if (w_start_ok)
        r_pass_cnt <= '0;
      else if (busy && w_pop && r_out_last && !(&r_pass_cnt))
        r_pass_cnt <= r_pass_cnt + 1'b1;
    end
  end

`ifdef RF_DAC_SRC_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where the DAC holds off a valid word
  always_ff @(posedge dac_usr_clk or negedge dac_usr_rstb) begin
    if (!dac_usr_rstb)
      r_stall_cnt <= '0;
    else if (w_start_ok)
      r_stall_cnt <= '0;
    else if (busy && r_out_vld && !m_axis_tready && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign err_len       = r_err;
  assign pass_cnt      = r_pass_cnt;
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tdata  = r_out_data;

endmodule

// File: tb/tb_rf_dac_stream_src.sv
// Directed bench for rf_dac_stream_src: single pass, loop with stop, stalled
// handshake, length errors, full-depth pass, mid-pass reset and len=1 looping.
module tb_rf_dac_stream_src;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rstb;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   cfg_len;
  logic              cfg_loop, start, stop, tready;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, busy, done, err_len;
  logic [CNT_W-1:0]  pass_cnt;
`ifdef RF_DAC_SRC_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_tot = 0;
  int n_bad = 0;

  rf_dac_stream_src #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .dac_usr_clk   (clk),
    .dac_usr_rstb  (rstb),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cfg_len       (cfg_len),
    .cfg_loop      (cfg_loop),
    .start         (start),
    .stop          (stop),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done),
    .pass_cnt      (pass_cnt),
`ifdef RF_DAC_SRC_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .err_len       (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] wd(input int i);
    logic [15:0] s;
    s = 16'(i + 1);
    return {16{s}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts playback and watches the stream until done. Cycle 1 is the cycle
  // after the start pulse; first valid word must appear in cycle 2.
  task automatic play(input int len, input bit loop, input int stop_at, input bit rnd_rdy,
                      input int budget, output int hs, output int stalls);
    logic [31:0]       pat;
    logic [DATA_W-1:0] prev_data;
    bit                prev_stall, got_done, seen_vld;
    int                last_hs;
    pat = 32'hB36A_5C91;
    hs = 0; stalls = 0; prev_stall = 0; got_done = 0; seen_vld = 0; last_hs = 0;
    prev_data = '0;
    cfg_len  = (ADDR_W + 1)'(len);
    cfg_loop = loop;
    start    = 1'b1;
    stop     = (stop_at == 0);
    tready   = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 1; cyc < budget; cyc++) begin
      tready = rnd_rdy ? pat[cyc % 32] : 1'b1;
      stop   = (cyc == stop_at);
      if (done) begin
        got_done = 1;
        check("done_gap", 256'(cyc - last_hs), 256'd1);
        check("end_tvalid", 256'(tvalid), 256'd0);
        check("end_busy", 256'(busy), 256'd0);
        break;
      end
      if (tvalid && !seen_vld) begin
        seen_vld = 1;
        check("latency", 256'(cyc), 256'd2);
      end
      if (prev_stall) begin
        check("stall_vld", 256'(tvalid), 256'd1);
        check("stall_data", tdata, prev_data);
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      if (tvalid && !tready) stalls++;
      if (tvalid && tready) begin
        check("data", tdata, wd(hs % len));
        hs++;
        last_hs = cyc;
      end
      tick;
    end
    stop   = 1'b0;
    tready = 1'b1;
    if (!got_done) check("done_timeout", 256'(got_done), 256'd1);
    tick;
    check("done_pulse_len", 256'(done), 256'd0);
  endtask

  int hs, stalls;

  initial begin
    rstb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_len = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b1;
    tick; tick;
    check("rst_tvalid", 256'(tvalid), 256'd0);
    check("rst_tdata", tdata, '0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_pass", 256'(pass_cnt), 256'd0);
    check("rst_err", 256'(err_len), 256'd0);
    rstb = 1'b1;
    tick;

    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_addr = ADDR_W'(i);
      wr_data = wd(i);
      tick;
    end
    wr_en = 1'b0;

    // single pass of 4; stop coincident with start in IDLE is ignored
    play(4, 1'b0, 0, 1'b0, 40, hs, stalls);
    check("t1_hs", 256'(hs), 256'd4);
    check("t1_pass", 256'(pass_cnt), 256'd1);

    // loop, stop during word index 9 (value 2): pass finishes at 12 words
    play(4, 1'b1, 11, 1'b0, 60, hs, stalls);
    check("t2_hs", 256'(hs), 256'd12);
    check("t2_pass", 256'(pass_cnt), 256'd3);

    // loop with stalled handshake, stop mid-stream
    play(4, 1'b1, 40, 1'b1, 200, hs, stalls);
    check("t3_whole", 256'(hs % 4), 256'd0);
    check("t3_pass", 256'(pass_cnt), 256'(hs / 4));
`ifdef RF_DAC_SRC_STALL_CNT_EN
    check("t3_stall_cnt", 256'(stall_cnt), 256'(stalls));
`endif

    // invalid lengths: 0 and 257
    cfg_len = '0; start = 1'b1;
    tick;
    start = 1'b0;
    check("len0_err", 256'(err_len), 256'd1);
    check("len0_busy", 256'(busy), 256'd0);
    check("len0_tvalid", 256'(tvalid), 256'd0);
    tick;
    check("len0_err_clr", 256'(err_len), 256'd0);
    cfg_len = 9'd257; start = 1'b1;
    tick;
    start = 1'b0;
    check("len257_err", 256'(err_len), 256'd1);
    check("len257_busy", 256'(busy), 256'd0);
    tick;

    // full depth
    play(256, 1'b0, -1, 1'b0, 300, hs, stalls);
    check("t4_hs", 256'(hs), 256'd256);
    check("t4_pass", 256'(pass_cnt), 256'd1);

    // mid-pass reset
    cfg_len = 9'd4; cfg_loop = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    check("rs_tvalid_pre", 256'(tvalid), 256'd1);
    #2 rstb = 1'b0;
    #1;
    check("rs_tvalid", 256'(tvalid), 256'd0);
    check("rs_busy", 256'(busy), 256'd0);
    tick;
    check("rs_done", 256'(done), 256'd0);
    rstb = 1'b1;
    tick;
    check("rs_done2", 256'(done), 256'd0);
    check("rs_pass", 256'(pass_cnt), 256'd0);
    play(4, 1'b0, -1, 1'b0, 40, hs, stalls);
    check("rs_replay_hs", 256'(hs), 256'd4);

    // len=1 loop with live RAM update
    cfg_len = 9'd1; cfg_loop = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("l1_vld", 256'(tvalid), 256'd1);
    check("l1_data", tdata, wd(0));
    check("l1_pass0", 256'(pass_cnt), 256'd0);
    tick;
    check("l1_pass1", 256'(pass_cnt), 256'd1);
    check("l1_data1", tdata, wd(0));
    wr_en = 1'b1; wr_addr = '0; wr_data = {8{32'hCAFE_0001}};
    tick;
    wr_en = 1'b0;
    check("l1_pass2", 256'(pass_cnt), 256'd2);
    tick; tick;
    check("l1_newdata", tdata, {8{32'hCAFE_0001}});
    check("l1_pass4", 256'(pass_cnt), 256'd4);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    check("l1_done", 256'(done), 256'd1);
    check("l1_tvalid", 256'(tvalid), 256'd0);
    check("l1_pass5", 256'(pass_cnt), 256'd5);
    tick;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
